fir_coeff_ctrl: RTL
===================

// Module: fir_coeff_ctrl
// PURPOSE
//  Configuration controller for the 9-tap pipelined lowpass FIR.
//  Holds a host-writable shadow coefficient bank and an active bank that drives the FIR multipliers.
//  Swaps shadow->active atomically on a sample_tick boundary, then masks the FIR output while its pipeline refills.
//  Sits between the host config bus and the FIR datapath.
// PARAMETERS
//  NUM_TAPS   9   number of coefficients / FIR taps
//  COEFF_W    16  signed coefficient width
//  PIPE_LAT   6   FIR input-to-output register latency, in cycles
//  ADDR_W     $clog2(NUM_TAPS)  config address width (localparam, derived)
// PORTS
//  clk           in   1                  system clock, 100 MHz sample rate
//  rst           in   1                  synchronous, active-high reset
//  cfg_addr      in   ADDR_W             tap index for write/readback
//  cfg_data      in   COEFF_W            coefficient write data (signed)
//  cfg_we        in   1                  shadow write strobe
//  cfg_commit    in   1                  request shadow->active swap
//  sample_tick   in   1                  swap-permitted boundary; tie 1 for immediate swap
//  cfg_rdata     out  COEFF_W            registered shadow readback of cfg_addr
//  cfg_busy      out  1                  1 while in PENDING
//  cfg_err       out  1                  1-cycle pulse on a rejected write
//  coeff_flat    out  NUM_TAPS*COEFF_W   active bank; tap k at [k*COEFF_W +: COEFF_W]
//  swap_pulse    out  1                  1-cycle pulse on the cycle the active bank updates
//  out_valid     out  1                  FIR filtered_signal is valid this cycle
// BEHAVIOUR
//  Reset state (rst=1 at an edge):
//   - Shadow and active banks load {04F6,0AE4,1089,1496,160F,1496,1089,0AE4,04F6} for NUM_TAPS=9; all 0 otherwise.
//   - cfg_rdata=0, cfg_busy=0, cfg_err=0, swap_pulse=0, out_valid=0.
//   - State <- SETTLE, settle counter <- S = NUM_TAPS+PIPE_LAT (15).
//   - rst mid-operation aborts any PENDING swap; the shadow is reloaded with the defaults.
//  FSM states: IDLE, PENDING, SETTLE.
//   IDLE:
//    - cfg_commit=1 -> PENDING.
//   PENDING:
//    - sample_tick=1 -> active<=shadow, swap_pulse=1, counter<=S, -> SETTLE.
//    - A tick in the same cycle as the commit does not swap; with tick tied 1 the swap occurs 1 cycle after the commit.
//   SETTLE:
//    - Counter decrements each cycle; at 0 -> IDLE.
//    - cfg_commit=1 -> PENDING; the active bank is unchanged until the next swap.
//  out_valid: 1 only in IDLE. After a swap edge T, out_valid=0 for cycles T..T+S-1 and 1 from T+S.
//  Writes (cfg_we=1):
//   - Allowed in IDLE and SETTLE: shadow[cfg_addr] <= cfg_data.
//   - In PENDING: ignored, cfg_err pulses.
//   - cfg_addr >= NUM_TAPS: ignored, cfg_err pulses.
//  Simultaneous cfg_we and cfg_commit in IDLE: the write lands first and is included in the swap.
//  cfg_commit while already in PENDING: ignored, no error.
//  cfg_rdata <= shadow[cfg_addr] every cycle (1-cycle latency); returns 0 if cfg_addr is out of range.
//  Active bank changes only on a swap edge; coeff_flat is registered (no combinational path from the cfg inputs).
// CONFIGURATION
//  FIR_CFG_SYM_EN defined:
//   - A valid write to addr k also writes addr NUM_TAPS-1-k (linear-phase mirroring).
//   - Writing the centre tap writes it once.
//  FIR_CFG_SYM_EN undefined: each write touches only cfg_addr.
// TESTING
//  1. Release rst, idle -> out_valid=0 for 15 cycles then 1; coeff_flat tap4=160F, tap0=04F6.
//  2. Write addr2=0x1234, read addr2 -> cfg_rdata=0x1234 next cycle; active tap2 stays 1089.
//     Commit with sample_tick=1 -> swap_pulse one cycle later, tap2=1234, out_valid low 15 cycles.
//  3. Commit with sample_tick=0 for 20 cycles -> cfg_busy=1 throughout.
//     cfg_we during that window -> cfg_err pulse, shadow unchanged.
//     Tick -> swap_pulse.
//  4. cfg_we to addr 9 -> cfg_err pulse, no bank change.
//     cfg_we+cfg_commit in the same cycle (addr0=0x7FFF) -> swapped tap0=7FFF.
//  5. Commit, then rst on the cycle before the tick -> no swap_pulse; all taps at defaults; out_valid low 15 cycles.
//  6. FIR_CFG_SYM_EN defined: write addr1=0x0100 -> shadow taps 1 and 7 = 0100.
//     Undefined: tap7 stays 0AE4.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// Coefficient bank controller for the 9-tap pipelined lowpass FIR: shadow/active banks,
// tick-aligned swap and output masking while the FIR refills. Optional macro: FIR_CFG_SYM_EN.
module fir_coeff_ctrl #(
    parameter  int unsigned NUM_TAPS = 9,
    parameter  int unsigned COEFF_W  = 16,
    parameter  int unsigned PIPE_LAT = 6,
    localparam int unsigned ADDR_W   = $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [COEFF_W-1:0]            cfg_data,
    input  logic                          cfg_we,
    input  logic                          cfg_commit,
    input  logic                          sample_tick,
    output logic [COEFF_W-1:0]            cfg_rdata,
    output logic                          cfg_busy,
    output logic                          cfg_err,
    output logic [NUM_TAPS*COEFF_W-1:0]   coeff_flat,
    output logic                          swap_pulse,
    output logic                          out_valid
);

    localparam int unsigned SETTLE_CYC = NUM_TAPS + PIPE_LAT;
    localparam int unsigned CNT_W      = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [COEFF_W-1:0]   shadow [NUM_TAPS];

    logic                 addr_ok_c;
    logic [COEFF_W-1:0]   rd_mux_c;
    logic [NUM_TAPS-1:0]  wr_hit_c;

    // Power-on lowpass taps; only defined for the 9-tap build.
    function automatic logic [COEFF_W-1:0] dflt_coeff(input int unsigned k);
        logic [COEFF_W-1:0] v;
        v = '0;
        if (NUM_TAPS == 9) begin
            case (k)
                0, 8:    v = COEFF_W'(16'h04F6);
                1, 7:    v = COEFF_W'(16'h0AE4);
                2, 6:    v = COEFF_W'(16'h1089);
                3, 5:    v = COEFF_W'(16'h1496);
                4:       v = COEFF_W'(16'h160F);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    assign addr_ok_c = (32'(cfg_addr) < NUM_TAPS);

    always_comb begin
        rd_mux_c = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (cfg_addr == ADDR_W'(k)) rd_mux_c = shadow[k];
        end
    end

    // Taps touched by a write; mirrored pair when symmetric writes are enabled.
    always_comb begin
        wr_hit_c = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef FIR_CFG_SYM_EN
            wr_hit_c[k] = (cfg_addr == ADDR_W'(k)) || (cfg_addr == ADDR_W'(NUM_TAPS - 1 - k));
`else
            wr_hit_c[k] = (cfg_addr == ADDR_W'(k));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= CNT_W'(SETTLE_CYC);
            cfg_rdata  <= '0;
            cfg_busy   <= 1'b0;
            cfg_err    <= 1'b0;
            swap_pulse <= 1'b0;
            out_valid  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k]                          <= dflt_coeff(k);
                coeff_flat[k*COEFF_W +: COEFF_W]   <= dflt_coeff(k);
            end
        end else begin
            cfg_rdata  <= rd_mux_c;
            cfg_err    <= 1'b0;
            swap_pulse <= 1'b0;

            // Shadow writes; rejected while a swap is armed or when out of range.
            if (cfg_we) begin
                if ((state == PENDING) || !addr_ok_c) begin
                    cfg_err <= 1'b1;
                end else begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (wr_hit_c[k]) shadow[k] <= cfg_data;
                    end
                end
            end

            case (state)
                IDLE: begin
                    out_valid <= 1'b1;
                    cfg_busy  <= 1'b0;
                    if (cfg_commit) begin
                        state     <= PENDING;
                        cfg_busy  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                PENDING: begin
                    cfg_busy  <= 1'b1;
                    out_valid <= 1'b0;
                    if (sample_tick) begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            coeff_flat[k*COEFF_W +: COEFF_W] <= shadow[k];
                        end
                        swap_pulse <= 1'b1;
                        settle_cnt <= CNT_W'(SETTLE_CYC);
                        state      <= SETTLE;
                        cfg_busy   <= 1'b0;
                    end
                end
                SETTLE: begin
                    cfg_busy  <= 1'b0;
                    out_valid <= 1'b0;
                    if (cfg_commit) begin
                        state    <= PENDING;
                        cfg_busy <= 1'b1;
                    end else if (settle_cnt <= CNT_W'(1)) begin
                        // Last masked cycle: valid rises exactly SETTLE_CYC cycles after the swap.
                        settle_cnt <= '0;
                        state      <= IDLE;
                        out_valid  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= SETTLE;
                    cfg_busy  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
